// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, sprite position type and the sprite hit test.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = 800;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = 525;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pos_t;

  // 17-bit sums so a sprite placed near 16'hFFFF never wraps back on screen.
  function automatic logic sprite_hit(input logic [9:0] h, input logic [9:0] v,
                                      input pos_t s, input int unsigned w,
                                      input int unsigned ht);
    logic [16:0] h17, v17, x0, y0, x1, y1;
    h17 = {7'd0, h};
    v17 = {7'd0, v};
    x0  = {1'b0, s.x};
    y0  = {1'b0, s.y};
    x1  = x0 + 17'(w);
    y1  = y0 + 17'(ht);
    return (h17 >= x0) && (h17 < x1) && (v17 >= y0) && (v17 < y1);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 timing generator: pixel enable, h/v counters and raw sync/active decode.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       pix_en_o,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic       active_o
);

  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_en_q;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_q) begin
      if (hcount_q == HLast) begin
        hcount_d = '0;
        vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_en_q <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      pix_en_q <= ~pix_en_q;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign pix_en_o  = pix_en_q;
  assign hcount_o  = hcount_q;
  assign vcount_o  = vcount_q;
  assign hsync_n_o = !((hcount_q >= HSyncStart) && (hcount_q < HSyncEnd));
  assign vsync_n_o = !((vcount_q >= VSyncStart) && (vcount_q < VSyncEnd));
  assign active_o  = (hcount_q < HActive) && (vcount_q < VActive);

endmodule

// File: rtl/vga_sprite_render.sv
// Renders three solid sprites (monster > p1 > p2) over a background on 640x480 VGA,
// using positions snapshotted once per frame at the start of vertical blank.
module vga_sprite_render
  import vga_pkg::*;
#(
  parameter int unsigned SPRITE_W = 16,
  parameter int unsigned SPRITE_H = 16,
  parameter logic [23:0] BG_RGB   = 24'h000000,
  parameter logic [23:0] M_RGB    = 24'hFF0000,
  parameter logic [23:0] P1_RGB   = 24'h00FF00,
  parameter logic [23:0] P2_RGB   = 24'h0000FF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] mx_i,
  input  logic [15:0] my_i,
  input  logic [15:0] p1x_i,
  input  logic [15:0] p1y_i,
  input  logic [15:0] p2x_i,
  input  logic [15:0] p2y_i,
  output logic        vga_clk_o,
  output logic        hsync_n_o,
  output logic        vsync_n_o,
  output logic        blank_n_o,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        frame_start_o
);

  logic       pix_en;
  logic [9:0] hcount, vcount;
  logic       hsync_raw_n, vsync_raw_n, active;

  vga_timing u_timing (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pix_en_o  (pix_en),
    .hcount_o  (hcount),
    .vcount_o  (vcount),
    .hsync_n_o (hsync_raw_n),
    .vsync_n_o (vsync_raw_n),
    .active_o  (active)
  );

  pos_t        m_q, p1_q, p2_q;
  logic        snap_en;
  logic        hit_m, hit_p1, hit_p2;
  logic [23:0] rgb_d, rgb_q;
  logic        hsync_n_q, vsync_n_q, blank_n_q, frame_start_q;

  always_comb begin
    snap_en = pix_en && (hcount == '0) && (vcount == 10'(V_ACTIVE));
    hit_m   = sprite_hit(hcount, vcount, m_q, SPRITE_W, SPRITE_H);
    hit_p1  = sprite_hit(hcount, vcount, p1_q, SPRITE_W, SPRITE_H);
    hit_p2  = sprite_hit(hcount, vcount, p2_q, SPRITE_W, SPRITE_H);
    rgb_d   = BG_RGB;
    if (!active)     rgb_d = '0;
    else if (hit_m)  rgb_d = M_RGB;
    else if (hit_p1) rgb_d = P1_RGB;
    else if (hit_p2) rgb_d = P2_RGB;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q           <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      frame_start_q <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
    end else begin
      // Toggles every clk, so the pulse lasts exactly one clk.
      frame_start_q <= snap_en;
      if (snap_en) begin
        m_q  <= '{x: mx_i, y: my_i};
        p1_q <= '{x: p1x_i, y: p1y_i};
        p2_q <= '{x: p2x_i, y: p2y_i};
      end
      if (pix_en) begin
        hsync_n_q <= hsync_raw_n;
        vsync_n_q <= vsync_raw_n;
        blank_n_q <= active;
        rgb_q     <= rgb_d;
      end
    end
  end

  assign vga_clk_o     = pix_en;
  assign hsync_n_o     = hsync_n_q;
  assign vsync_n_o     = vsync_n_q;
  assign blank_n_o     = blank_n_q;
  assign r_o           = rgb_q[23:16];
  assign g_o           = rgb_q[15:8];
  assign b_o           = rgb_q[7:0];
  assign frame_start_o = frame_start_q;

endmodule
